// File: rtl/mailbox_apb_arbiter.sv
// Round-robin arbiter sharing the mailbox core port among per-CPU APB front-ends.
// One transaction at a time: IDLE picks a winner, BUSY drives the core, DONE pulses done_o.
module mailbox_apb_arbiter #(
  parameter int N_NUMB_CPU  = 4,
  parameter int W_WIDTH_SYS = 32,
  parameter int WIDTH_ADDR  = 32,
  parameter int TIMEOUT     = 16,
  parameter int IDW         = $clog2(N_NUMB_CPU)
) (
  input  logic                                    pclk_i,
  input  logic                                    presetn_i,
  input  logic [N_NUMB_CPU-1:0]                   req_i,
  input  logic [N_NUMB_CPU-1:0]                   req_we_i,
  input  logic [N_NUMB_CPU-1:0][WIDTH_ADDR-1:0]   req_addr_i,
  input  logic [N_NUMB_CPU-1:0][W_WIDTH_SYS-1:0]  req_wdata_i,
  output logic [N_NUMB_CPU-1:0]                   done_o,
  output logic [W_WIDTH_SYS-1:0]                  rsp_rdata_o,
  output logic                                    rsp_err_o,
  output logic                                    mb_valid_o,
  output logic                                    mb_we_o,
  output logic [WIDTH_ADDR-1:0]                   mb_addr_o,
  output logic [W_WIDTH_SYS-1:0]                  mb_wdata_o,
  output logic [IDW-1:0]                          mb_src_o,
  input  logic                                    mb_ready_i,
  input  logic [W_WIDTH_SYS-1:0]                  mb_rdata_i,
  input  logic                                    mb_err_i,
  output logic                                    busy_o
);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef struct packed {
    logic                   we;
    logic [WIDTH_ADDR-1:0]  addr;
    logic [W_WIDTH_SYS-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic                   err;
    logic [W_WIDTH_SYS-1:0] rdata;
  } rsp_t;

  logic [1:0]     state_q;
  logic [IDW-1:0] win_q, last_q, pick;
  logic           pick_vld;
  req_t           req_q;
  rsp_t           rsp_q;
  logic [CW-1:0]  cnt_q;
  int             idx;

  // First requester found walking upward from last+1, wrapping.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 1; i <= N_NUMB_CPU; i++) begin
      idx = (int'(last_q) + i) % N_NUMB_CPU;
      if (!pick_vld && req_i[IDW'(idx)]) begin
        pick     = IDW'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk_i or negedge presetn_i) begin
    if (!presetn_i) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(N_NUMB_CPU - 1);
      win_q   <= '0;
      req_q   <= '0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (pick_vld) begin
          win_q   <= pick;
          req_q   <= '{we: req_we_i[pick], addr: req_addr_i[pick], wdata: req_wdata_i[pick]};
          cnt_q   <= '0;
          state_q <= S_BUSY;
        end
        S_BUSY: begin
          if (mb_ready_i) begin
            rsp_q   <= '{err: mb_err_i, rdata: (req_q.we ? '0 : mb_rdata_i)};
            state_q <= S_DONE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            rsp_q   <= '{err: 1'b1, rdata: '0};
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          last_q  <= win_q;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  logic in_done;
  assign in_done     = (state_q == S_DONE);
  assign busy_o      = (state_q != S_IDLE);
  assign mb_valid_o  = (state_q == S_BUSY);
  // Core port reads as zero outside BUSY so idle bus values never leak stale data.
  assign mb_we_o     = mb_valid_o & req_q.we;
  assign mb_addr_o   = mb_valid_o ? req_q.addr  : '0;
  assign mb_wdata_o  = mb_valid_o ? req_q.wdata : '0;
  assign mb_src_o    = mb_valid_o ? win_q       : '0;
  assign rsp_rdata_o = in_done ? rsp_q.rdata : '0;
  assign rsp_err_o   = in_done & rsp_q.err;

  for (genvar g = 0; g < N_NUMB_CPU; g++) begin : g_done
    assign done_o[g] = in_done & (win_q == IDW'(g));
  end
endmodule

// File: tb/tb_mailbox_apb_arbiter.sv
// Bench for mailbox_apb_arbiter: vector table, directed corner sequences,
// then random traffic compared against a transaction-level reference model.
module tb_mailbox_apb_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic             pclk_i = 1'b0;
  logic             presetn_i;
  logic [3:0]       req, req_we;
  logic [3:0][31:0] req_addr, req_wdata;
  logic [3:0]       done_o;
  logic [31:0]      rsp_rdata_o, mb_addr_o, mb_wdata_o, mb_rdata_i;
  logic             rsp_err_o, mb_valid_o, mb_we_o, mb_ready_i, mb_err_i, busy_o;
  logic [1:0]       mb_src_o;

  mailbox_apb_arbiter #(.N_NUMB_CPU(N), .W_WIDTH_SYS(32), .WIDTH_ADDR(32), .TIMEOUT(TO)) dut (
    .pclk_i(pclk_i), .presetn_i(presetn_i),
    .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .done_o(done_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .mb_valid_o(mb_valid_o), .mb_we_o(mb_we_o), .mb_addr_o(mb_addr_o),
    .mb_wdata_o(mb_wdata_o), .mb_src_o(mb_src_o), .mb_ready_i(mb_ready_i),
    .mb_rdata_i(mb_rdata_i), .mb_err_i(mb_err_i), .busy_o(busy_o)
  );

  always #5 pclk_i = ~pclk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk_i);
    @(negedge pclk_i);
  endtask

  function automatic logic [127:0] mk(input logic b, input logic vl, input logic w,
                                      input logic [1:0] s, input logic [31:0] a,
                                      input logic [31:0] wd, input logic [3:0] d,
                                      input logic re, input logic [31:0] rr);
    return {22'b0, b, vl, w, s, a, wd, d, re, rr};
  endfunction

  function automatic logic [127:0] dut_pack();
    return mk(busy_o, mb_valid_o, mb_we_o, mb_src_o, mb_addr_o, mb_wdata_o,
              done_o, rsp_err_o, rsp_rdata_o);
  endfunction

  typedef struct packed {
    logic [3:0]   req;
    logic [3:0]   we;
    logic         rdy;
    logic [31:0]  rdata;
    logic [127:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic [3:0] rq, input logic [3:0] we, input logic rdy,
                             input logic [31:0] rd, input logic [127:0] ex);
    return '{req: rq, we: we, rdy: rdy, rdata: rd, exp: ex};
  endfunction

  task automatic run_tbl(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; req_we = tbl[i].we;
      mb_ready_i = tbl[i].rdy; mb_rdata_i = tbl[i].rdata;
      tick();
      chk($sformatf("%s%0d", tag, i), dut_pack(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  task automatic do_reset();
    presetn_i = 1'b0;
    #1 chk("reset_outs", dut_pack(), 128'h0);
    @(negedge pclk_i) presetn_i = 1'b1;
  endtask

  // Reference model: tracks the owning CPU, elapsed core-wait cycles and the
  // pending response; the winner is the requester nearest after the last one.
  int          m_owner, m_last, m_age;
  bit          m_in_done;
  logic        m_we, m_rerr;
  logic [31:0] m_addr, m_wdata, m_rrd;

  function automatic void model_reset();
    m_owner = -1; m_last = N - 1; m_age = 0; m_in_done = 0;
    m_we = 0; m_addr = 0; m_wdata = 0; m_rrd = 0; m_rerr = 0;
  endfunction

  function automatic void model_step();
    if (m_in_done) begin
      m_last = m_owner; m_owner = -1; m_in_done = 0;
    end else if (m_owner >= 0) begin
      m_age++;
      if (mb_ready_i) begin
        m_in_done = 1; m_rerr = mb_err_i; m_rrd = m_we ? 32'h0 : mb_rdata_i;
      end else if (m_age == TO) begin
        m_in_done = 1; m_rerr = 1; m_rrd = 0;
      end
    end else if (req != 0) begin
      int best = -1, bestd = N;
      for (int i = 0; i < N; i++)
        if (req[i] && ((i - m_last - 1 + N) % N) < bestd) begin
          best = i; bestd = (i - m_last - 1 + N) % N;
        end
      m_owner = best; m_age = 0;
      m_we = req_we[best]; m_addr = req_addr[best]; m_wdata = req_wdata[best];
    end
  endfunction

  function automatic logic [127:0] model_pack();
    logic vl;
    vl = (m_owner >= 0) && !m_in_done;
    return mk(m_owner >= 0, vl, vl & m_we, vl ? 2'(m_owner) : 2'd0,
              vl ? m_addr : 32'h0, vl ? m_wdata : 32'h0,
              m_in_done ? 4'(1 << m_owner) : 4'h0,
              m_in_done & m_rerr, m_in_done ? m_rrd : 32'h0);
  endfunction

  int  cnt, pct, just_done;
  bit  got, stable;

  initial begin
    req = '0; req_we = '0; mb_ready_i = 0; mb_rdata_i = 0; mb_err_i = 0;
    for (int i = 0; i < N; i++) begin
      req_addr[i]  = 32'(8 + 4 * i);
      req_wdata[i] = 32'(16 + i);
    end
    do_reset();

    // Single read from CPU0, ready on the first BUSY cycle.
    tbl.push_back(v(4'b0001, 4'b0000, 1'b0, 32'h0,        mk(1, 1, 0, 0, 32'h8, 32'h10, 4'h0, 0, 32'h0)));
    tbl.push_back(v(4'b0001, 4'b0000, 1'b1, 32'hA5A50001, mk(1, 0, 0, 0, 32'h0, 32'h0, 4'h1, 0, 32'hA5A50001)));
    tbl.push_back(v(4'b0000, 4'b0000, 1'b0, 32'h0,        128'h0));
    run_tbl("single");

    do_reset();
    // Full contention of writes; ready held high throughout.
    tbl.push_back(v(4'hF, 4'hF, 1, 32'hDEADBEEF, mk(1, 1, 1, 0, 32'h8,  32'h10, 4'h0, 0, 0)));
    tbl.push_back(v(4'hF, 4'hF, 1, 32'hDEADBEEF, mk(1, 0, 0, 0, 0, 0, 4'h1, 0, 0)));
    tbl.push_back(v(4'hE, 4'hF, 1, 32'hDEADBEEF, 128'h0));
    tbl.push_back(v(4'hE, 4'hF, 1, 32'hDEADBEEF, mk(1, 1, 1, 1, 32'hC,  32'h11, 4'h0, 0, 0)));
    tbl.push_back(v(4'hE, 4'hF, 1, 32'hDEADBEEF, mk(1, 0, 0, 0, 0, 0, 4'h2, 0, 0)));
    tbl.push_back(v(4'hC, 4'hF, 1, 32'hDEADBEEF, 128'h0));
    tbl.push_back(v(4'hC, 4'hF, 1, 32'hDEADBEEF, mk(1, 1, 1, 2, 32'h10, 32'h12, 4'h0, 0, 0)));
    tbl.push_back(v(4'hC, 4'hF, 1, 32'hDEADBEEF, mk(1, 0, 0, 0, 0, 0, 4'h4, 0, 0)));
    tbl.push_back(v(4'h8, 4'hF, 1, 32'hDEADBEEF, 128'h0));
    tbl.push_back(v(4'h8, 4'hF, 1, 32'hDEADBEEF, mk(1, 1, 1, 3, 32'h14, 32'h13, 4'h0, 0, 0)));
    tbl.push_back(v(4'h8, 4'hF, 1, 32'hDEADBEEF, mk(1, 0, 0, 0, 0, 0, 4'h8, 0, 0)));
    tbl.push_back(v(4'h1, 4'hF, 1, 32'hDEADBEEF, 128'h0));
    tbl.push_back(v(4'h1, 4'hF, 1, 32'hDEADBEEF, mk(1, 1, 1, 0, 32'h8,  32'h10, 4'h0, 0, 0)));
    tbl.push_back(v(4'h1, 4'hF, 1, 32'hDEADBEEF, mk(1, 0, 0, 0, 0, 0, 4'h1, 0, 0)));
    tbl.push_back(v(4'h0, 4'hF, 0, 32'hDEADBEEF, 128'h0));
    run_tbl("contend");

    // Timeout: CPU2 read, core never answers.
    req_we = '0; mb_ready_i = 0; mb_rdata_i = 32'h12345678; req[2] = 1;
    cnt = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (mb_valid_o) cnt++;
      if (done_o != 0) got = 1;
    end
    chk("to_valid_cycles", 128'(cnt), 128'(TO));
    chk("to_done", done_o, 4'b0100);
    chk("to_err", rsp_err_o, 1);
    chk("to_rdata", rsp_rdata_o, 0);
    req[2] = 0; tick();
    chk("to_idle", busy_o, 0);

    // Core error after a 5-cycle stall on a CPU1 write.
    req[1] = 1; req_we[1] = 1; stable = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!(mb_valid_o && mb_we_o && mb_src_o == 2'd1 && mb_addr_o == 32'hC && mb_wdata_o == 32'h11))
        stable = 0;
    end
    chk("stall_stable", stable, 1);
    mb_ready_i = 1; mb_err_i = 1; mb_rdata_i = 32'hFFFF0000; tick();
    chk("stall_done", done_o, 4'b0010);
    chk("stall_err", rsp_err_o, 1);
    chk("stall_wr_rdata", rsp_rdata_o, 0);
    mb_ready_i = 0; mb_err_i = 0; req[1] = 0; req_we[1] = 0; tick();

    // Reset while CPU3 is stalled; CPU1 pending must win afterwards.
    req[3] = 1; tick(); tick(); tick();
    req[1] = 1;
    #2 presetn_i = 0;
    #1 chk("rst_busy_outs", dut_pack(), 128'h0);
    @(negedge pclk_i);
    chk("rst_held_outs", dut_pack(), 128'h0);
    presetn_i = 1;
    tick();
    chk("rst_regrant_src", {mb_valid_o, mb_src_o, done_o}, {1'b1, 2'd1, 4'h0});
    mb_ready_i = 1; mb_rdata_i = 32'h42; tick();
    chk("rst_cpu1_done", {done_o, rsp_rdata_o}, {4'b0010, 32'h42});
    req[1] = 0; mb_ready_i = 0; tick(); tick();
    chk("rst_cpu3_next", {mb_valid_o, mb_src_o}, {1'b1, 2'd3});
    mb_ready_i = 1; tick();
    chk("rst_cpu3_done", done_o, 4'b1000);
    req[3] = 0; mb_ready_i = 0; tick();

    // Late request: CPU0 arrives while CPU3 is in BUSY.
    req[3] = 1; tick(); tick(); tick();
    chk("late_grant3", {mb_valid_o, mb_src_o}, {1'b1, 2'd3});
    req[0] = 1; mb_ready_i = 1; tick();
    chk("late_done3", {done_o, mb_valid_o}, {4'b1000, 1'b0});
    req[3] = 0; mb_ready_i = 0; tick();
    chk("late_idle", {busy_o, done_o}, 0);
    tick();
    chk("late_grant0", {mb_valid_o, mb_src_o}, {1'b1, 2'd0});
    mb_ready_i = 1; tick();
    chk("late_done0", done_o, 4'b0001);
    req[0] = 0; mb_ready_i = 0; tick();

    // Random traffic against the reference model.
    req = '0;
    do_reset();
    model_reset();
    just_done = -1; pct = 50;
    for (int c = 0; c < 600; c++) begin
      if (c % 50 == 0)
        case ($urandom_range(0, 3))
          0: pct = 0;
          1: pct = 25;
          2: pct = 60;
          default: pct = 100;
        endcase
      mb_ready_i = ($urandom_range(0, 99) < pct);
      mb_rdata_i = $urandom;
      mb_err_i   = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        if (!req[i] && i != just_done && $urandom_range(0, 2) == 0) begin
          req[i] = 1; req_we[i] = 1'($urandom_range(0, 1));
          req_addr[i] = $urandom; req_wdata[i] = $urandom;
        end
      @(posedge pclk_i);
      model_step();
      @(negedge pclk_i);
      chk($sformatf("rand%0d", c), dut_pack(), model_pack());
      just_done = -1;
      if (m_in_done) begin
        req[m_owner] = 0;
        just_done = m_owner;
      end
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
